// File: rtl/rf_wb_arbiter.sv
// Purpose : shares the single register-file write port among NUM_REQ writeback requesters (round-robin).
// Latency : grant in cycle N -> rf_we/rf_addr/rf_wdata registered at the end of N, stable through N+1.
// Backpr. : req_ready is a combinational one-hot grant; zero during the clear sweep and while rf_hold is high.
//
// Ports:
//   clk, rst                 clock (rising edge) and asynchronous active-high reset
//   req_valid/addr/data      per-requester write requests; addr slice [5i+4:5i], data slice [32i+31:32i]
//   req_ready                one-hot grant; a transfer happens when req_valid[i] & req_ready[i]
//   rf_hold                  freezes arbitration while high (ignored during the clear sweep)
//   rf_we/rf_addr/rf_wdata   registered write port to the register file (captured on its falling edge)
//   init_done                high once the post-reset clear of x1..x31 has completed
//   stall_cnt_clr, stall_cnt only with RF_WB_STALL_CNT_EN defined: saturating count of RUN cycles
//                            in which some valid requester was not granted
//
// Optional feature macro: RF_WB_STALL_CNT_EN (undefined by default).
module rf_wb_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [5*NUM_REQ-1:0]  req_addr,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  rf_hold,
    output logic                  rf_we,
    output logic [4:0]            rf_addr,
    output logic [31:0]           rf_wdata,
`ifdef RF_WB_STALL_CNT_EN
    input  logic                  stall_cnt_clr,
    output logic [15:0]           stall_cnt,
`endif
    output logic                  init_done
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
    localparam logic   RST_DONE  = (CLEAR_ON_RESET == 0);

    state_t        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_addr_q, rf_addr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;
    logic          init_done_q, init_done_d;

    logic [NUM_REQ-1:0] gnt;
    logic               gnt_any;
    logic [PW-1:0]      gnt_idx;
    logic [4:0]         gnt_addr;
    logic [31:0]        gnt_data;
    int                 idx;

    // Rotating-priority pick: scan from the RR pointer upward, wrapping at NUM_REQ-1.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
        // No grants during the clear sweep or while the pipeline asks us to hold.
        if (state_q != ST_RUN || rf_hold) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Select the granted requester's address and data.
    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == PW'(i)) begin
                gnt_addr = req_addr[5*i +: 5];
                gnt_data = req_data[32*i +: 32];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: the sweep ends once x31 has been issued.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && cnt_q == 5'd31) begin
            state_d = ST_RUN;
        end
    end

    // FSM outputs and datapath next values.
    always_comb begin
        req_ready   = '0;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        rf_we_d     = 1'b0;
        rf_addr_d   = rf_addr_q;
        rf_wdata_d  = rf_wdata_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                rf_we_d    = 1'b1;
                rf_addr_d  = cnt_q;
                rf_wdata_d = '0;
                cnt_d      = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    init_done_d = 1'b1;
                end
            end
            default: begin
                req_ready = gnt;
                if (gnt_any) begin
                    // x0 writes are accepted from the requester but never reach the port.
                    rf_we_d    = (gnt_addr != 5'd0);
                    rf_addr_d  = gnt_addr;
                    rf_wdata_d = gnt_data;
                    ptr_d      = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
        endcase
    end

    // Datapath registers; reset discards any accepted-but-unissued write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= 5'd1;
            ptr_q       <= '0;
            rf_we_q     <= 1'b0;
            rf_addr_q   <= '0;
            rf_wdata_q  <= '0;
            init_done_q <= RST_DONE;
        end else begin
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            rf_we_q     <= rf_we_d;
            rf_addr_q   <= rf_addr_d;
            rf_wdata_q  <= rf_wdata_d;
            init_done_q <= init_done_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_addr   = rf_addr_q;
    assign rf_wdata  = rf_wdata_q;
    assign init_done = init_done_q;

`ifdef RF_WB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall;

    // A stall is a RUN cycle where at least one valid requester was left waiting.
    always_comb begin
        stall       = (state_q == ST_RUN) && (|(req_valid & ~gnt));
        stall_cnt_d = stall_cnt_q;
        if (stall_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
